// File: rtl/axi4_read_packetizer.sv
// Cuts an AXI4-Stream from the read-data FIFO into packets of cfg_pkt_beats beats, with TLAST on the final beat.
// Optional feature: define PKTZR_TIMEOUT_EN to abort a stalled packet after TIMEOUT_CYCLES idle STREAM cycles.
module axi4_read_packetizer #(
  parameter int DATA_W         = 512,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LEN_W-1:0]    cfg_pkt_beats,
  input  logic                cfg_start,
  output logic                busy,
  output logic                pkt_done,
  output logic [LEN_W-1:0]    beat_count,
  output logic                timeout_err,
  output logic [1:0]          dbg_state,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0] S_AXIS_TKEEP,
  input  logic                S_AXIS_TVALID,
  input  logic                S_AXIS_TLAST,
  output logic                S_AXIS_TREADY,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
  output logic                M_AXIS_TVALID,
  output logic                M_AXIS_TLAST,
  input  logic                M_AXIS_TREADY
);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FINISH = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   mem_data [2];
  logic [DATA_W/8-1:0] mem_keep [2];
  logic [1:0]          mem_last;
  logic                rd_ptr, wr_ptr;
  logic [1:0]          count, count_nxt;
  logic                s_ready_q;
  logic                s_hs, m_hs, start_ok, last_beat, flush;
  logic                unused_tlast;

  // Handshakes: a beat transfers on a rising edge where VALID and READY are both 1;
  // VALID never waits on READY, and a raised VALID holds its payload until it transfers.
  assign s_hs          = S_AXIS_TVALID & s_ready_q;
  assign m_hs          = M_AXIS_TVALID & M_AXIS_TREADY;
  assign start_ok      = cfg_start && (cfg_pkt_beats != '0);
  assign last_beat     = (beat_count + LEN_W'(1)) == len_q;
  assign unused_tlast  = S_AXIS_TLAST;

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TVALID = (count != 2'd0);
  assign M_AXIS_TDATA  = mem_data[rd_ptr];
  assign M_AXIS_TKEEP  = mem_keep[rd_ptr];
  assign M_AXIS_TLAST  = M_AXIS_TVALID & mem_last[rd_ptr];
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

`ifdef PKTZR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt;
  logic            to_err_q;

  assign flush       = (state == STREAM) && !s_hs && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = to_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      to_err_q <= 1'b0;
    end else begin
      if ((state == STREAM) && !s_hs) idle_cnt <= idle_cnt + TO_W'(1);
      else                            idle_cnt <= '0;
      if (flush) to_err_q <= 1'b1;
    end
  end
`else
  assign flush       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pkt_done  = 1'b0;
    unique case (state)
      IDLE:   if (start_ok) state_nxt = STREAM;
      STREAM: begin
        if (flush)                  state_nxt = IDLE;
        else if (s_hs && last_beat) state_nxt = FINISH;
      end
      FINISH: begin
        if (m_hs && M_AXIS_TLAST) begin
          pkt_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (flush)               count_nxt = 2'd0;
    else if (s_hs && !m_hs)  count_nxt = count + 2'd1;
    else if (!s_hs && m_hs)  count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      beat_count <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      s_ready_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // Ready is registered from next-cycle occupancy, so M_AXIS_TREADY never reaches it combinationally.
      s_ready_q <= (state_nxt == STREAM) && (count_nxt != 2'd2);
      if ((state == IDLE) && start_ok) begin
        len_q      <= cfg_pkt_beats;
        beat_count <= '0;
      end else if (s_hs && (beat_count != len_q)) begin
        beat_count <= beat_count + LEN_W'(1);
      end
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (s_hs) wr_ptr <= ~wr_ptr;
        if (m_hs) rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_hs) begin
      mem_data[wr_ptr] <= S_AXIS_TDATA;
      mem_keep[wr_ptr] <= S_AXIS_TKEEP;
      mem_last[wr_ptr] <= last_beat;
    end
  end

endmodule

// File: tb/tb_axi4_read_packetizer.sv
// Randomized bench for axi4_read_packetizer: packet-level reference model plus a beat scoreboard.
// Set PKTZR_TIMEOUT_EN at compile time to exercise the idle-timeout path.
module tb_axi4_read_packetizer;
  localparam int DATA_W = 32;
  localparam int KEEP_W = DATA_W / 8;
  localparam int LEN_W  = 8;
  localparam int TO_CYC = 16;
  localparam int W      = DATA_W + KEEP_W + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [LEN_W-1:0]  cfg_pkt_beats = '0;
  logic              cfg_start = 1'b0;
  logic              busy, pkt_done, timeout_err;
  logic [LEN_W-1:0]  beat_count;
  logic [1:0]        dbg_state;
  logic [DATA_W-1:0] s_tdata = '0;
  logic [KEEP_W-1:0] s_tkeep = '0;
  logic              s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic              m_tvalid, m_tlast;
  logic              m_tready = 1'b0;

  axi4_read_packetizer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_pkt_beats(cfg_pkt_beats), .cfg_start(cfg_start),
    .busy(busy), .pkt_done(pkt_done), .beat_count(beat_count), .timeout_err(timeout_err),
    .dbg_state(dbg_state),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // packet-level model
  bit m_busy = 0, m_to = 0;
  int m_len = 0, m_acc = 0, m_idle = 0;
  int s_prob = 100, m_prob = 100;
  bit s_taken = 0;
  bit hold_v = 0;
  logic [W:0] hold_d = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: new source beat only after the previous one transferred
  task automatic drive();
    if (s_taken || !s_tvalid) begin
      s_tvalid = ($urandom_range(99) < s_prob);
      s_tdata  = $urandom;
      s_tkeep  = KEEP_W'($urandom_range(15));
      s_tlast  = 1'($urandom_range(1));
    end
    m_tready = ($urandom_range(99) < m_prob);
  endtask

  // sample #1 after the inputs settle, update model/scoreboard, advance one cycle
  task automatic tick();
    bit s_hs, m_hs, done_exp, busy_pre;
    logic [W-1:0] e;
    #1;
    s_hs = s_tvalid && s_tready;
    m_hs = m_tvalid && m_tready;
    busy_pre = m_busy;
    done_exp = 0;
    check("busy", busy, m_busy);
    check("beat_count", beat_count, m_acc);
    check("timeout_err", timeout_err, m_to);
    check("m_valid", m_tvalid, exp_q.size() != 0);
    check("s_ready_gate", s_tready && !(m_busy && m_acc < m_len), 1'b0);
    if (hold_v) check("m_stable", {m_tvalid, m_tlast, m_tkeep, m_tdata}, hold_d);
    hold_v = m_tvalid && !m_tready;
    hold_d = {m_tvalid, m_tlast, m_tkeep, m_tdata};
    if (m_hs) begin
      if (exp_q.size() == 0) check("m_unexpected", 1'b1, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("m_beat", {m_tlast, m_tkeep, m_tdata}, e);
        done_exp = e[W-1];
      end
    end
    check("pkt_done", pkt_done, done_exp);
`ifdef PKTZR_TIMEOUT_EN
    if (busy_pre && m_acc < m_len && !s_hs) begin
      m_idle++;
      if (m_idle == TO_CYC) begin
        exp_q.delete();
        m_busy = 0;
        m_to = 1;
        m_idle = 0;
        hold_v = 0;
      end
    end else m_idle = 0;
`endif
    if (s_hs) begin
      m_acc++;
      exp_q.push_back({(m_acc == m_len), s_tkeep, s_tdata});
    end
    if (done_exp) m_busy = 0;
    if (!busy_pre && cfg_start && cfg_pkt_beats != 0) begin
      m_busy = 1;
      m_len = int'(cfg_pkt_beats);
      m_acc = 0;
    end
    s_taken = s_hs;
    @(negedge clk);
  endtask

  task automatic cycle();
    drive();
    tick();
  endtask

  task automatic run_pkt(input int len, input int sp, input int mp);
    int n;
    s_prob = sp;
    m_prob = mp;
    cfg_start = 1'b1;
    cfg_pkt_beats = LEN_W'(len);
    cycle();
    cfg_start = 1'b0;
    n = 0;
    while (m_busy && n < 500) begin
      cycle();
      n++;
    end
    if (m_busy) check("pkt_budget", 1'b1, 1'b0);
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_tready", s_tready, 1'b0);
    check("rst_mvalid", m_tvalid, 1'b0);
    check("rst_mlast", m_tlast, 1'b0);
    check("rst_count", beat_count, '0);
    check("rst_done", pkt_done, 1'b0);
    check("rst_to", timeout_err, 1'b0);
    exp_q.delete();
    m_busy = 0; m_acc = 0; m_len = 0; m_to = 0; m_idle = 0;
    hold_v = 0; s_taken = 0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bit pulsed;
    @(negedge clk);
    tick();
    tick();
    do_reset();
    cycle();

    // length 4, source and sink always ready
    run_pkt(4, 100, 100);
    // length 8 under random sink backpressure
    run_pkt(8, 100, 50);

    // zero length start is ignored, then a mid-packet start is ignored
    cfg_start = 1'b1;
    cfg_pkt_beats = '0;
    cycle();
    cfg_start = 1'b0;
    cycle();
    s_prob = 70; m_prob = 70;
    cfg_start = 1'b1;
    cfg_pkt_beats = LEN_W'(6);
    cycle();
    cfg_start = 1'b0;
    pulsed = 0;
    n = 0;
    while (m_busy && n < 500) begin
      if (!pulsed && m_acc >= 2) begin
        cfg_start = 1'b1;
        cfg_pkt_beats = LEN_W'(3);
        pulsed = 1;
      end else cfg_start = 1'b0;
      cycle();
      n++;
    end
    cfg_start = 1'b0;
    if (m_busy) check("pkt_budget", 1'b1, 1'b0);
    check("orig_len_kept", m_acc, 6);
    cycle();

    // reset after beat 2 of 5, then a clean length-2 packet
    s_prob = 100; m_prob = 30;
    cfg_start = 1'b1;
    cfg_pkt_beats = LEN_W'(5);
    cycle();
    cfg_start = 1'b0;
    n = 0;
    while (m_acc < 2 && n < 100) begin
      cycle();
      n++;
    end
    do_reset();
    cycle();
    run_pkt(2, 100, 100);

    // random packets
    for (int i = 0; i < 20; i++)
      run_pkt($urandom_range(12, 1), $urandom_range(100, 30), $urandom_range(100, 30));

    // source stall after beat 1 of 4
    s_prob = 100; m_prob = 100;
    cfg_start = 1'b1;
    cfg_pkt_beats = LEN_W'(4);
    cycle();
    cfg_start = 1'b0;
    n = 0;
    while (m_busy && n < 3 * TO_CYC) begin
      if (m_acc >= 1) s_prob = 0;
      cycle();
      n++;
    end
`ifdef PKTZR_TIMEOUT_EN
    check("timeout_idle", busy, 1'b0);
    check("timeout_flag", timeout_err, 1'b1);
    cycle();
    do_reset();
    cycle();
`else
    check("stall_waits", busy, 1'b1);
    check("stall_no_to", timeout_err, 1'b0);
    s_prob = 100;
    n = 0;
    while (m_busy && n < 100) begin
      cycle();
      n++;
    end
    if (m_busy) check("pkt_budget", 1'b1, 1'b0);
    cycle();
`endif
    run_pkt(3, 100, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi4_read_packetizer.md
AXI4_READ_PACKETIZER -- requirements
Module: axi4_read_packetizer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 512: AXIS data width in bits; TKEEP width is DATA_W/8.
REQ-002 The block SHALL have parameter LEN_W, default 16: width of the packet beat-count fields.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: idle-cycle limit, used only when PKTZR_TIMEOUT_EN is defined.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cfg_pkt_beats  in  LEN_W  beats per packet, sampled on an accepted start.
REQ-008 cfg_start  in  1  single-cycle start request.
REQ-009 busy  out  1  high while not IDLE.
REQ-010 pkt_done  out  1  one-cycle pulse after the last beat handshakes on M.
REQ-011 beat_count  out  LEN_W  number of beats accepted on S in the current packet.
REQ-012 timeout_err  out  1  sticky idle-timeout flag.
REQ-013 S_AXIS_TDATA/TKEEP/TVALID/TLAST/TREADY  in/in/in/in/out  DATA_W/DATA_W/8/1/1/1  upstream stream from the read-data FIFO; S_AXIS_TLAST is ignored.
REQ-014 M_AXIS_TDATA/TKEEP/TVALID/TLAST/TREADY  out/out/out/out/in  DATA_W/DATA_W/8/1/1/1  stream to DMA S2MM.

Function
REQ-015 The FSM SHALL have three states: IDLE, STREAM, FINISH.
REQ-016 In IDLE, cfg_start=1 with cfg_pkt_beats!=0 SHALL latch the length, clear beat_count and enter STREAM on the next cycle.
REQ-017 In IDLE, cfg_start=1 with cfg_pkt_beats==0 SHALL be ignored.
REQ-018 cfg_start in STREAM or FINISH SHALL be ignored and SHALL NOT alter the latched length.
REQ-019 S_AXIS_TREADY SHALL be 0 in IDLE and FINISH; in STREAM it SHALL be 1 whenever the output stage can accept a beat.
REQ-020 The output stage SHALL be a two-entry skid buffer: full throughput, S_AXIS_TREADY registered, no combinational path from M_AXIS_TREADY to S_AXIS_TREADY.
REQ-021 The latency from an S handshake to M_AXIS_TVALID SHALL be 1 cycle when M is ready.
REQ-022 TDATA/TKEEP SHALL pass through unmodified, in order, with no loss or duplication under arbitrary M_AXIS_TREADY backpressure.
REQ-023 M_AXIS_TLAST SHALL be 1 only on beat number N (N = latched length) and 0 on all others.
REQ-024 When beat N is accepted on S, the FSM SHALL enter FINISH.
REQ-025 In FINISH, the M handshake of the TLAST beat SHALL pulse pkt_done for exactly 1 cycle, coincident with that handshake, and the FSM SHALL return to IDLE on the next cycle.
REQ-026 M_AXIS_TVALID, once asserted, SHALL hold with stable data until M_AXIS_TREADY=1.
REQ-027 beat_count SHALL increment on each S handshake, saturate at the latched length, and hold its value in IDLE until the next accepted start.

Reset
REQ-028 While rst_n=0 the block SHALL force: state=IDLE; busy=0; pkt_done=0; beat_count=0; timeout_err=0; S_AXIS_TREADY=0; M_AXIS_TVALID=0; M_AXIS_TLAST=0; skid buffer empty.
REQ-029 Reset asserted mid-packet SHALL discard buffered beats, with no partial TLAST afterwards.
REQ-030 Outputs SHALL become valid on the first clk edge after rst_n deasserts.

Configuration
REQ-031 With macro PKTZR_TIMEOUT_EN defined, a counter SHALL count consecutive STREAM cycles with no S handshake.
REQ-032 With PKTZR_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES SHALL set timeout_err (sticky until reset), flush the skid buffer without emitting TLAST, and return the FSM to IDLE without pulsing pkt_done.
REQ-033 Without PKTZR_TIMEOUT_EN, timeout_err SHALL be constant 0, no counter logic SHALL exist, and STREAM SHALL wait indefinitely.

Verification
REQ-034 Start with length 4, S valid continuously, M ready=1: 4 M beats on consecutive cycles; TLAST on beat 4 only; pkt_done 1 cycle on beat 4's handshake; busy low the next cycle.
REQ-035 Length 8, M_AXIS_TREADY toggling 1/0 randomly: all 8 beats arrive in order with data intact; S_AXIS_TREADY never high in FINISH.
REQ-036 cfg_start with length 0, then a start at length 3 issued mid-packet: both ignored; the running packet completes with its original length.
REQ-037 rst_n pulsed low after beat 2 of 5: all outputs return to reset values immediately; the next packet of length 2 is clean.
REQ-038 With PKTZR_TIMEOUT_EN, TIMEOUT_CYCLES=16, S stalls after beat 1 of 4: timeout_err=1 after 16 cycles, FSM returns to IDLE, no pkt_done; without the macro, timeout_err stays 0.
